// File: rtl/signal_sequencer.sv
// Timed RED -> GREEN -> YELLOW -> RED signal sequencer with pedestrian request/ack handshake.
// Define SEQ_ALLRED_EN to insert an ALLRED clearance state between YELLOW and RED.
module signal_sequencer #(
    parameter int unsigned RED_CYCLES    = 8,
    parameter int unsigned GREEN_CYCLES  = 10,
    parameter int unsigned YELLOW_CYCLES = 3,
    parameter int unsigned MIN_GREEN     = 4,
    parameter int unsigned ALLRED_CYCLES = 2,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             ped_req,
    output logic             ped_ack,
    output logic [2:0]       color,
    output logic             color_chg,
    output logic [CNT_W-1:0] remaining
);

    localparam logic [2:0] ST_RED    = 3'b000;
    localparam logic [2:0] ST_GREEN  = 3'b001;
    localparam logic [2:0] ST_YELLOW = 3'b010;
    localparam logic [2:0] ST_ALLRED = 3'b011;

    localparam logic [CNT_W-1:0] LOAD_RED    = CNT_W'(RED_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOAD_GREEN  = CNT_W'(GREEN_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOAD_YELLOW = CNT_W'(YELLOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOAD_ALLRED = CNT_W'(ALLRED_CYCLES - 1);
    // GREEN has been held MIN_GREEN cycles once remaining drops to this value
    localparam logic [CNT_W-1:0] GREEN_EXIT_AT = CNT_W'(GREEN_CYCLES - MIN_GREEN);

    logic [2:0]       state;
    logic [2:0]       next_state;
    logic [CNT_W-1:0] next_load;
    logic             pending;
    logic             early_exit;
    logic             dwell_done;
    logic             advance;
    logic             serve_ped;

    assign color = state;

    always_comb begin
        early_exit = (state == ST_GREEN) && pending && (remaining <= GREEN_EXIT_AT);
        dwell_done = (remaining == '0);
        advance    = enable && (early_exit || dwell_done);
        serve_ped  = advance && (next_state == ST_RED) && pending;
    end

    always_comb begin
        next_state = ST_RED;
        case (state)
            ST_RED:    next_state = ST_GREEN;
            ST_GREEN:  next_state = ST_YELLOW;
`ifdef SEQ_ALLRED_EN
            ST_YELLOW: next_state = ST_ALLRED;
`else
            ST_YELLOW: next_state = ST_RED;
`endif
            ST_ALLRED: next_state = ST_RED;
            default:   next_state = ST_RED;
        endcase
    end

    always_comb begin
        next_load = LOAD_RED;
        case (next_state)
            ST_RED:    next_load = LOAD_RED;
            ST_GREEN:  next_load = LOAD_GREEN;
            ST_YELLOW: next_load = LOAD_YELLOW;
            ST_ALLRED: next_load = LOAD_ALLRED;
            default:   next_load = LOAD_RED;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_RED;
            remaining <= LOAD_RED;
            color_chg <= 1'b0;
        end else begin
            color_chg <= advance;
            if (advance) begin
                state     <= next_state;
                remaining <= next_load;
            end else if (enable) begin
                remaining <= remaining - 1'b1;
            end
        end
    end

    // Ack release follows ped_req even while timing is frozen
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending <= 1'b0;
            ped_ack <= 1'b0;
        end else begin
            if (serve_ped) begin
                pending <= 1'b0;
                ped_ack <= 1'b1;
            end else begin
                if (enable && ped_req && !ped_ack && !pending)
                    pending <= 1'b1;
                if (ped_ack && !ped_req)
                    ped_ack <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_signal_sequencer.sv
// Self-checking bench for signal_sequencer: directed scenarios plus randomized traffic
// compared against a phase/elapsed-time reference model.
module tb_signal_sequencer;

    localparam int RED_C    = 8;
    localparam int GREEN_C  = 10;
    localparam int YELLOW_C = 3;
    localparam int MIN_G    = 4;
    localparam int ALLRED_C = 2;
`ifdef SEQ_ALLRED_EN
    localparam bit HAS_ALLRED = 1'b1;
`else
    localparam bit HAS_ALLRED = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       enable = 1'b0;
    logic       ped_req = 1'b0;
    logic       ped_ack;
    logic [2:0] color;
    logic       color_chg;
    logic [7:0] remaining;

    int n_checks = 0;
    int n_pass = 0;

    // Reference model: phase (spec color code), enabled cycles spent in phase, handshake flags
    int m_ph;
    int m_held;
    bit m_pend;
    bit m_ack;
    bit m_chg;

    signal_sequencer #(
        .RED_CYCLES   (RED_C),
        .GREEN_CYCLES (GREEN_C),
        .YELLOW_CYCLES(YELLOW_C),
        .MIN_GREEN    (MIN_G),
        .ALLRED_CYCLES(ALLRED_C),
        .CNT_W        (8)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .enable   (enable),
        .ped_req  (ped_req),
        .ped_ack  (ped_ack),
        .color    (color),
        .color_chg(color_chg),
        .remaining(remaining)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    endtask

    function automatic int dwell(input int ph);
        case (ph)
            0: return RED_C;
            1: return GREEN_C;
            2: return YELLOW_C;
            default: return ALLRED_C;
        endcase
    endfunction

    function automatic int next_phase(input int ph);
        case (ph)
            0: return 1;
            1: return 2;
            2: return HAS_ALLRED ? 3 : 0;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_ph = 0; m_held = 0; m_pend = 0; m_ack = 0; m_chg = 0;
    endtask

    task automatic model_step(input bit en, input bit req);
        bit new_pend;
        bit new_ack;
        bit leave;
        new_pend = m_pend;
        new_ack  = m_ack;
        m_chg    = 0;
        if (m_ack && !req) new_ack = 0;
        if (en) begin
            if (req && !m_ack && !m_pend) new_pend = 1;
            leave = (m_held + 1 >= dwell(m_ph)) ||
                    (m_ph == 1 && m_pend && m_held + 1 >= MIN_G);
            if (leave) begin
                m_ph   = next_phase(m_ph);
                m_held = 0;
                m_chg  = 1;
                if (m_ph == 0 && m_pend) begin
                    new_ack  = 1;
                    new_pend = 0;
                end
            end else begin
                m_held++;
            end
        end
        m_pend = new_pend;
        m_ack  = new_ack;
    endtask

    task automatic compare_all();
        check("color", color, m_ph);
        check("remaining", remaining, dwell(m_ph) - 1 - m_held);
        check("color_chg", color_chg, m_chg);
        check("ped_ack", ped_ack, m_ack);
    endtask

    task automatic tick(input bit en, input bit req);
        enable  = en;
        ped_req = req;
        @(posedge clk);
        model_step(en, req);
        #1;
        compare_all();
    endtask

    // Ticks until the DUT pulses color_chg; n = ticks taken, or -1 if the budget expires
    task automatic run_until_chg(input bit en, input bit req, output int n);
        n = -1;
        for (int i = 1; i <= 64; i++) begin
            tick(en, req);
            if (color_chg === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic do_reset();
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        int n;
        int period;
        bit en;
        bit req;

        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check("rst_color", color, 0);
        check("rst_remaining", remaining, RED_C - 1);
        check("rst_ack", ped_ack, 0);
        check("rst_chg", color_chg, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Free-running sequence, no requests
        run_until_chg(1, 0, n); check("red_len", n, RED_C); period = n;
        run_until_chg(1, 0, n); check("green_len", n, GREEN_C); period += n;
        run_until_chg(1, 0, n); check("yellow_len", n, YELLOW_C); period += n;
        if (HAS_ALLRED) begin
            check("allred_color", color, 3);
            run_until_chg(1, 0, n); check("allred_len", n, ALLRED_C); period += n;
        end
        check("period", period, HAS_ALLRED ? 23 : 21);

        // Request in GREEN cycle 1 shortens GREEN to MIN_GREEN
        run_until_chg(1, 0, n); check("red_len2", n, RED_C);
        tick(1, 1);
        run_until_chg(1, 1, n); check("green_short", n + 1, MIN_G);
        run_until_chg(1, 1, n); check("yellow_after_short", n, YELLOW_C);
        if (HAS_ALLRED) begin
            check("ack_not_on_allred", ped_ack, 0);
            run_until_chg(1, 1, n); check("allred_len2", n, ALLRED_C);
        end
        check("ack_on_red", ped_ack, 1);
        tick(1, 1);
        check("ack_held", ped_ack, 1);
        tick(1, 0);
        check("ack_drop", ped_ack, 0);
        run_until_chg(1, 0, n); check("red_rest", n, RED_C - 2);

        // Freeze mid-GREEN at remaining 6
        for (int i = 0; i < 3; i++) tick(1, 0);
        check("green_rem6", remaining, 6);
        for (int i = 0; i < 5; i++) begin
            tick(0, 0);
            check("frozen_rem", remaining, 6);
            check("frozen_color", color, 1);
        end
        run_until_chg(1, 0, n); check("green_resume", n, 7);

        // Request latched in YELLOW, then reset drops it
        tick(1, 1);
        do_reset();
        check("mid_rst_color", color, 0);
        check("mid_rst_rem", remaining, RED_C - 1);
        check("mid_rst_ack", ped_ack, 0);
        run_until_chg(1, 0, n); check("red_after_rst", n, RED_C);
        run_until_chg(1, 0, n); check("green_full_after_rst", n, GREEN_C);

        // Randomized traffic against the model
        req = 0;
        for (int i = 0; i < 4000; i++) begin
            en = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 5) == 0) req = ~req;
            tick(en, req);
            if ($urandom_range(0, 599) == 0) do_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
